// File: rtl/gate_mon_pkg.sv
// Shared definitions for the gate-word sequence monitor.
//
// Purpose: legal gate-word constants, phase bit positions, fault codes,
// monitor state encodings and small helper functions.
//
// Gate word layout, MSB first: {A+, A-, B+, B-, C+, C-}.
package gate_mon_pkg;

  // Phase bit positions in the 6-bit gate word
  localparam int unsigned BIT_A_P = 5;
  localparam int unsigned BIT_A_N = 4;
  localparam int unsigned BIT_B_P = 3;
  localparam int unsigned BIT_B_N = 2;
  localparam int unsigned BIT_C_P = 1;
  localparam int unsigned BIT_C_N = 0;

  // Masks selecting every high-side (+) or low-side (-) device
  localparam logic [5:0] PLUS_MASK  = 6'b101010;
  localparam logic [5:0] MINUS_MASK = 6'b010101;

  // Legal words
  localparam logic [5:0] W_OFF    = 6'b000000;
  localparam logic [5:0] W_FULL_A = 6'b110000;
  localparam logic [5:0] W_FULL_B = 6'b001100;
  localparam logic [5:0] W_FULL_C = 6'b000011;
  localparam logic [5:0] W_OV_0   = 6'b101000;
  localparam logic [5:0] W_OV_1   = 6'b010100;
  localparam logic [5:0] W_OV_2   = 6'b001010;
  localparam logic [5:0] W_OV_3   = 6'b000101;
  localparam logic [5:0] W_OV_4   = 6'b100010;
  localparam logic [5:0] W_OV_5   = 6'b010001;

  // Fault codes
  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_STEP    = 3'd2;
  localparam logic [2:0] FC_SIGN    = 3'd3;
  localparam logic [2:0] FC_DWELL   = 3'd4;
  localparam logic [2:0] FC_OVERLAP = 3'd5;

  // Monitor states
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;
  localparam logic [1:0] ST_ARM   = 2'd2;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_word_classify.sv
// Combinational classifier for one gate word.
//
// Ports:
//   word       in   6  word to classify (current gate_in)
//   prev       in   6  previously sampled word (gate_q)
//   is_legal   out  1  word is in the legal set
//   is_off     out  1  word is all-off
//   is_full    out  1  word is a full-phase word (both devices of one leg)
//   is_overlap out  1  word is a two-phase overlap word
//   diff_cnt   out  3  number of devices that differ between word and prev
module gate_word_classify
  import gate_mon_pkg::*;
(
  input  logic [5:0] word,
  input  logic [5:0] prev,
  output logic       is_legal,
  output logic       is_off,
  output logic       is_full,
  output logic       is_overlap,
  output logic [2:0] diff_cnt
);

  logic is_single;

  always_comb begin
    is_off     = (word == W_OFF);
    is_single  = (popcount6(word) == 3'd1);
    is_full    = (word == W_FULL_A) || (word == W_FULL_B) || (word == W_FULL_C);
    is_overlap = (word == W_OV_0) || (word == W_OV_1) || (word == W_OV_2) ||
                 (word == W_OV_3) || (word == W_OV_4) || (word == W_OV_5);
    is_legal   = is_off || is_single || is_full || is_overlap;
    diff_cnt   = popcount6(word ^ prev);
  end

endmodule

// File: rtl/gate_seq_monitor.sv
// Independent checker on the gate word sent from the commutation FSM to the
// gate drivers. Latches the first fault and raises short_out, which forces
// the FSM to all-off.
//
// Optional feature: define SIGN_CHECK_EN to check that, when leaving a
// full-phase word, the retained device matches current_sign.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   gate_in      in   6      gate word {A+,A-,B+,B-,C+,C-}
//   current_sign in   1      source phase current sign, 1 = positive
//   fault_clr    in   1      one-cycle clear request
//   short_out    out  1      latched fault, drives FSM Short
//   fault_code   out  3      0 none,1 ILLEGAL,2 STEP,3 SIGN,4 DWELL,5 OVERLAP
//   fault_count  out  CNT_W  saturating count of latched faults
//   state_dbg    out  2      current monitor state (RUN/FAULT/ARM)
//
// Interface: no handshake. gate_in is sampled on every rising edge; all
// outputs are registered levels valid one cycle after the sampling edge.
module gate_seq_monitor
  import gate_mon_pkg::*;
#(
  parameter int MIN_DWELL   = 4,
  parameter int MAX_OVERLAP = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       gate_in,
  input  logic             current_sign,
  input  logic             fault_clr,
  output logic             short_out,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0] OVL_LIM   = CNT_W'(MAX_OVERLAP);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       state_q,       state_d;
  logic [5:0]       gate_q,        gate_d;
  logic [CNT_W-1:0] dwell_cnt_q,   dwell_cnt_d;
  logic [CNT_W-1:0] overlap_cnt_q, overlap_cnt_d;
  logic [CNT_W-1:0] arm_cnt_q,     arm_cnt_d;
  logic             short_q,       short_d;
  logic [2:0]       code_q,        code_d;
  logic [CNT_W-1:0] count_q,       count_d;

  logic       is_legal, is_off, is_full, is_overlap;
  logic [2:0] diff_cnt;
  logic       changed, off_edge;
  logic       step_bad, dwell_bad, ovl_bad, sign_bad;
  logic [2:0] fault_sel;

  gate_word_classify u_classify (
    .word       (gate_in),
    .prev       (gate_q),
    .is_legal   (is_legal),
    .is_off     (is_off),
    .is_full    (is_full),
    .is_overlap (is_overlap),
    .diff_cnt   (diff_cnt)
  );

`ifdef SIGN_CHECK_EN
  // Remembers whether the previously sampled word was a full-phase word.
  logic       full_q;
  logic [5:0] kept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= is_full;
  end

  // The device still on after leaving a full-phase word must be the
  // high side for positive current and the low side for negative current.
  always_comb begin
    kept     = gate_in & gate_q;
    sign_bad = full_q && changed && (kept != W_OFF) &&
               ((kept & (current_sign ? PLUS_MASK : MINUS_MASK)) == W_OFF);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{current_sign, is_full};
  assign sign_bad   = 1'b0;
`endif

  // Violation detection and counter next-state
  always_comb begin
    gate_d   = gate_in;
    changed  = (gate_in != gate_q);
    // Moves into or out of all-off are exempt from STEP and DWELL.
    off_edge = is_off || (gate_q == W_OFF);

    dwell_cnt_d   = '0;
    overlap_cnt_d = '0;
    if (state_q == ST_RUN) begin
      if (!changed) begin
        dwell_cnt_d = (dwell_cnt_q == CNT_MAX) ? dwell_cnt_q : dwell_cnt_q + 1'b1;
      end
      if (is_overlap) begin
        overlap_cnt_d = (overlap_cnt_q == CNT_MAX) ? overlap_cnt_q : overlap_cnt_q + 1'b1;
      end
    end

    step_bad  = changed && !off_edge && (diff_cnt > 3'd1);
    dwell_bad = changed && !off_edge && (dwell_cnt_q < DWELL_LIM);
    ovl_bad   = is_overlap && (overlap_cnt_d >= OVL_LIM);

    if      (!is_legal) fault_sel = FC_ILLEGAL;
    else if (step_bad)  fault_sel = FC_STEP;
    else if (sign_bad)  fault_sel = FC_SIGN;
    else if (dwell_bad) fault_sel = FC_DWELL;
    else if (ovl_bad)   fault_sel = FC_OVERLAP;
    else                fault_sel = FC_NONE;
  end

  // Monitor FSM
  always_comb begin
    state_d   = state_q;
    short_d   = short_q;
    code_d    = code_q;
    count_d   = count_q;
    arm_cnt_d = '0;

    case (state_q)
      ST_RUN: begin
        if (fault_sel != FC_NONE) begin
          state_d = ST_FAULT;
          short_d = 1'b1;
          code_d  = fault_sel;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        end
      end
      ST_FAULT: begin
        // The clear cycle itself counts as the first all-off cycle.
        if (fault_clr && is_off) begin
          state_d   = ST_ARM;
          arm_cnt_d = CNT_W'(1);
        end
      end
      ST_ARM: begin
        if (is_off) begin
          if (arm_cnt_q >= DWELL_LIM) begin
            state_d = ST_RUN;
            short_d = 1'b0;
            code_d  = FC_NONE;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // Unreachable encoding: fail safe with the short asserted.
        state_d = ST_FAULT;
        short_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      gate_q        <= W_OFF;
      dwell_cnt_q   <= '0;
      overlap_cnt_q <= '0;
      arm_cnt_q     <= '0;
      short_q       <= 1'b0;
      code_q        <= FC_NONE;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      dwell_cnt_q   <= dwell_cnt_d;
      overlap_cnt_q <= overlap_cnt_d;
      arm_cnt_q     <= arm_cnt_d;
      short_q       <= short_d;
      code_q        <= code_d;
      count_q       <= count_d;
    end
  end

  assign short_out   = short_q;
  assign fault_code  = code_q;
  assign fault_count = count_q;
  assign state_dbg   = state_q;

endmodule
